alu_cmd_sequencer: RTL

- Upstream issue stage for the 4-bit `alu` datapath.
- Accepts operation commands over a valid/ready handshake and registers the operands and opcode onto the ALU's `a`/`b`/`status` inputs.
- Captures the ALU's combinational `result` one cycle later and returns it over a valid/ready response channel, with a carry/borrow flag and a zero flag.
- Keeps the last result in an accumulator so a command can chain on the previous result.

---
 rtl/alu_cmd_sequencer.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/alu_cmd_sequencer.sv
// Issue stage for the 4-bit ALU: registers command operands onto the ALU inputs,
// captures the combinational result one cycle later and returns it with carry/zero flags.
module alu_cmd_sequencer #(
   parameter int WIDTH    = 4,
   parameter bit CHAIN_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_a,
   input  logic [WIDTH-1:0] cmd_b,
   input  logic             cmd_chain,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [1:0]       alu_status,
   input  logic [WIDTH-1:0] alu_result,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_result,
   output logic [1:0]       rsp_op,
   output logic             rsp_carry,
   output logic             rsp_zero,
   output logic [WIDTH-1:0] acc,
   output logic             busy
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] EXEC = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_SHA = 2'b10;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] alu_a_q, alu_a_d;
   logic [WIDTH-1:0] alu_b_q, alu_b_d;
   logic [1:0]       alu_status_q, alu_status_d;
   logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
   logic [1:0]       rsp_op_q, rsp_op_d;
   logic             rsp_carry_q, rsp_carry_d;
   logic             rsp_zero_q, rsp_zero_d;
   logic [WIDTH-1:0] acc_q, acc_d;

   logic             accept;
   logic             use_acc;
   logic [WIDTH:0]   sum_ext;
   logic             carry_calc;

   assign cmd_ready = (state_q == IDLE) | ((state_q == RESP) & rsp_ready);
   assign accept    = cmd_valid & cmd_ready;
   assign use_acc   = cmd_chain & CHAIN_EN;

   // Flag is derived from the registered ALU operands, never from alu_result.
   always_comb begin
      sum_ext    = {1'b0, alu_a_q} + {1'b0, alu_b_q};
      carry_calc = 1'b0;
      case (alu_status_q)
         OP_ADD:  carry_calc = sum_ext[WIDTH];
         OP_SUB:  carry_calc = (alu_a_q < alu_b_q);
         OP_SHA:  carry_calc = alu_a_q[WIDTH-1];
         default: carry_calc = alu_b_q[WIDTH-1];
      endcase
   end

   // In RESP, acc_q already holds the result being returned, so a chained
   // back-to-back command picks it up directly.
   always_comb begin
      state_d      = state_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      alu_status_d = alu_status_q;
      rsp_result_d = rsp_result_q;
      rsp_op_d     = rsp_op_q;
      rsp_carry_d  = rsp_carry_q;
      rsp_zero_d   = rsp_zero_q;
      acc_d        = acc_q;

      if (accept) begin
         alu_a_d      = use_acc ? acc_q : cmd_a;
         alu_b_d      = cmd_b;
         alu_status_d = cmd_op;
      end

      case (state_q)
         IDLE: begin
            if (accept) state_d = EXEC;
         end
         EXEC: begin
            rsp_result_d = alu_result;
            acc_d        = alu_result;
            rsp_op_d     = alu_status_q;
            rsp_carry_d  = carry_calc;
            rsp_zero_d   = (alu_result == '0);
            state_d      = RESP;
         end
         RESP: begin
            if (rsp_ready) state_d = accept ? EXEC : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_status_q <= '0;
         rsp_result_q <= '0;
         rsp_op_q     <= '0;
         rsp_carry_q  <= 1'b0;
         rsp_zero_q   <= 1'b0;
         acc_q        <= '0;
      end else begin
         state_q      <= state_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         alu_status_q <= alu_status_d;
         rsp_result_q <= rsp_result_d;
         rsp_op_q     <= rsp_op_d;
         rsp_carry_q  <= rsp_carry_d;
         rsp_zero_q   <= rsp_zero_d;
         acc_q        <= acc_d;
      end
   end

   assign alu_a      = alu_a_q;
   assign alu_b      = alu_b_q;
   assign alu_status = alu_status_q;
   assign rsp_valid  = (state_q == RESP);
   assign rsp_result = rsp_result_q;
   assign rsp_op     = rsp_op_q;
   assign rsp_carry  = rsp_carry_q;
   assign rsp_zero   = rsp_zero_q;
   assign acc        = acc_q;
   assign busy       = (state_q != IDLE);

endmodule
